// File: rtl/ofm_post_quant_if.sv
// ofm_post_quant_if: packed-word output stream of the OFM post-processing stage.
//   out_data  : 64-bit packed word, byte 0 = [7:0] is the oldest element
//   out_bytes : number of valid bytes in out_data (1..8)
//   out_valid : word available
//   out_ready : consumer accepts when out_valid && out_ready
// master = producer (ofm_post_quant), slave = write-back consumer.
interface ofm_post_quant_if;
   logic [63:0] out_data;
   logic [3:0]  out_bytes;
   logic        out_valid;
   logic        out_ready;

   modport master (output out_data, out_bytes, out_valid, input out_ready);
   modport slave  (input out_data, out_bytes, out_valid, output out_ready);
endinterface

// File: rtl/ofm_post_quant.sv
// ofm_post_quant: ReLU + requantize (right-shift, saturate to u8) of the two
// accelerator partial-sum ports, byte packing into 64-bit words and a small
// output FIFO. The accelerator cannot stall, so a push into a full FIFO with
// no simultaneous pop drops the word and sets the sticky overflow flag.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start                   : arms the block for a new layer (IDLE only)
//   end_conv                : last element has been presented (RUN only)
//   cfg_shift[4:0]          : requant shift, latched on start
//   ofm_port0/1, _v         : signed IN_W-bit elements A/B and valids
//   ob (master)             : out_data/out_bytes/out_valid/out_ready stream
//   overflow                : sticky word-dropped flag, cleared by reset/start
//   done                    : one-cycle pulse when the layer is fully drained
//   busy                    : high in any state other than IDLE
//
// Build option: OFM_POST_ROUND_EN selects round-half-up requantization;
// without it the shift truncates.
module ofm_post_quant #(
   parameter int IN_W       = 25,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 end_conv,
   input  logic [4:0]           cfg_shift,
   input  logic [IN_W-1:0]      ofm_port0,
   input  logic                 ofm_port0_v,
   input  logic [IN_W-1:0]      ofm_port1,
   input  logic                 ofm_port1_v,
   ofm_post_quant_if.master     ob,
   output logic                 overflow,
   output logic                 done,
   output logic                 busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
   state_t state;

   logic [4:0]  shift;
   logic [7:0]  s1_a, s1_b;
   logic        s1_va, s1_vb;
   logic [63:0] pk_word, pk_word_n, w;
   logic [2:0]  pk_cnt, pk_cnt_n;
   logic [3:0]  c;
   logic        push;
   logic [63:0] push_word;
   logic [3:0]  push_bytes;

   logic [67:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt, cnt_n;
   logic          ov, pop, full, wr_ok;

   // ReLU, shift (optionally rounded), saturate. The add is done one bit
   // wider than the input so the rounding term cannot wrap.
   function automatic logic [7:0] quant(input logic [IN_W-1:0] x, input logic [4:0] sh);
      logic [IN_W:0] r;
      r = x[IN_W-1] ? '0 : {1'b0, x};
`ifdef OFM_POST_ROUND_EN
      if (sh != 5'd0) r = r + ((IN_W+1)'(1) << (sh - 5'd1));
`endif
      r = r >> sh;
      return (r > (IN_W+1)'(255)) ? 8'hFF : r[7:0];
   endfunction

   // Packer: A before B. Count 7 plus two bytes completes the word with A and
   // starts the next with B, so at most one full word is produced per cycle.
   // A partial word is emitted in FLUSH, or in DRAIN when FLUSH already had a
   // full-word push that cycle (the FIFO accepts only one write per cycle).
   always_comb begin
      w          = pk_word;
      c          = {1'b0, pk_cnt};
      push       = 1'b0;
      push_word  = '0;
      push_bytes = '0;
      if (s1_va) begin
         w[{c[2:0], 3'b000} +: 8] = s1_a;
         c = c + 4'd1;
         if (c == 4'd8) begin
            push = 1'b1; push_word = w; push_bytes = 4'd8; w = '0; c = '0;
         end
      end
      if (s1_vb) begin
         w[{c[2:0], 3'b000} +: 8] = s1_b;
         c = c + 4'd1;
         if (c == 4'd8) begin
            push = 1'b1; push_word = w; push_bytes = 4'd8; w = '0; c = '0;
         end
      end
      if (c != 4'd0 && ((state == FLUSH && !push) || state == DRAIN)) begin
         push = 1'b1; push_word = w; push_bytes = c; w = '0; c = '0;
      end
      pk_word_n = w;
      pk_cnt_n  = c[2:0];
   end

   assign pop   = ov && ob.out_ready;
   assign full  = (cnt == CW'(FIFO_DEPTH));
   assign wr_ok = push && (!full || pop);
   assign cnt_n = cnt + CW'(wr_ok) - CW'(pop);

   assign ob.out_valid = ov;
   assign ob.out_data  = mem[rd_ptr][63:0];
   assign ob.out_bytes = mem[rd_ptr][67:64];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         shift    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_va    <= 1'b0;
         s1_vb    <= 1'b0;
         pk_word  <= '0;
         pk_cnt   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         ov       <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done    <= 1'b0;
         s1_a    <= quant(ofm_port0, shift);
         s1_b    <= quant(ofm_port1, shift);
         s1_va   <= (state == RUN) && ofm_port0_v;
         s1_vb   <= (state == RUN) && ofm_port1_v;
         pk_word <= pk_word_n;
         pk_cnt  <= pk_cnt_n;
         if (wr_ok) begin
            mem[wr_ptr] <= {push_bytes, push_word};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt_n;
         ov  <= (cnt_n != '0);
         if (push && full && !pop) overflow <= 1'b1;

         case (state)
            IDLE: if (start) begin
               state    <= RUN;
               busy     <= 1'b1;
               shift    <= cfg_shift;
               overflow <= 1'b0;
               pk_word  <= '0;
               pk_cnt   <= '0;
               s1_va    <= 1'b0;
               s1_vb    <= 1'b0;
               wr_ptr   <= '0;
               rd_ptr   <= '0;
               cnt      <= '0;
               ov       <= 1'b0;
            end
            RUN:   if (end_conv) state <= FLUSH;
            FLUSH: state <= DRAIN;
            DRAIN: if (cnt == '0 && pk_cnt == '0) begin
               state <= IDLE;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ofm_post_quant.sv
module tb_ofm_post_quant;
   localparam int IN_W = 25;

   logic            clk = 1'b0;
   logic            rst_n, start, end_conv;
   logic [4:0]      cfg_shift;
   logic [IN_W-1:0] ofm_port0, ofm_port1;
   logic            ofm_port0_v, ofm_port1_v;
   logic            overflow, done, busy;
   ofm_post_quant_if ob ();

   int n_chk = 0;
   int n_bad = 0;
   logic [67:0] q[$];

   ofm_post_quant #(.IN_W(IN_W), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .end_conv(end_conv),
      .cfg_shift(cfg_shift),
      .ofm_port0(ofm_port0), .ofm_port0_v(ofm_port0_v),
      .ofm_port1(ofm_port1), .ofm_port1_v(ofm_port1_v),
      .ob(ob), .overflow(overflow), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record every accepted word; inputs only change just after posedge.
   always @(negedge clk)
      if (ob.out_valid && ob.out_ready) q.push_back({ob.out_bytes, ob.out_data});

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic elem(input int a, input bit va, input int b, input bit vb, input bit ec);
      ofm_port0 = a[IN_W-1:0]; ofm_port0_v = va;
      ofm_port1 = b[IN_W-1:0]; ofm_port1_v = vb;
      end_conv = ec;
      step();
      ofm_port0_v = 1'b0; ofm_port1_v = 1'b0; end_conv = 1'b0;
   endtask

   task automatic do_start(input logic [4:0] sh);
      q.delete();
      cfg_shift = sh; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         step();
         if (done) seen = 1'b1;
      end
      chk({tag, "_done"}, 64'(seen), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      step();
      chk({tag, "_dpulse"}, 64'(done), 64'd0);
   endtask

   task automatic qchk(input string tag, input int idx, input logic [63:0] d, input logic [3:0] nb);
      if (idx < q.size()) begin
         chk({tag, "_data"}, q[idx][63:0], d);
         chk({tag, "_bytes"}, 64'(q[idx][67:64]), 64'(nb));
      end else begin
         chk({tag, "_qsize"}, 64'(q.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      logic [63:0] wexp;
      rst_n = 1'b0; start = 1'b0; end_conv = 1'b0; cfg_shift = '0;
      ofm_port0 = '0; ofm_port1 = '0; ofm_port0_v = 1'b0; ofm_port1_v = 1'b0;
      ob.out_ready = 1'b0;
      step(); step();
      chk("rst_valid", 64'(ob.out_valid), 64'd0);
      chk("rst_data",  ob.out_data, 64'd0);
      chk("rst_bytes", 64'(ob.out_bytes), 64'd0);
      chk("rst_ovf",   64'(overflow), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      rst_n = 1'b1;
      ob.out_ready = 1'b1;
      step();

      // 1..8 on port0, shift 0: one full word, valid two edges after the 8th
      do_start(5'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      for (int i = 1; i <= 8; i++) elem(i, 1'b1, 0, 1'b0, 1'b0);
      chk("t1_lat_k", 64'(ob.out_valid), 64'd0);
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      chk("t1_lat_k1", 64'(ob.out_valid), 64'd1);
      chk("t1_head", ob.out_data, 64'h0807060504030201);
      chk("t1_hbytes", 64'(ob.out_bytes), 64'd8);
      wait_done("t1");
      chk("t1_nwords", 64'(q.size()), 64'd1);

      // ReLU and saturation on both ports, partial flush of 2 bytes
      do_start(5'd4);
      elem(-100, 1'b1, 5000, 1'b1, 1'b0);
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      wait_done("t2");
      chk("t2_nwords", 64'(q.size()), 64'd1);
      qchk("t2_w0", 0, 64'h000000000000FF00, 4'd2);

      // rounding / truncation and saturation boundaries at shift 4
      do_start(5'd4);
      elem(24, 1'b1, 0, 1'b0, 1'b0);
      elem(23, 1'b1, 0, 1'b0, 1'b0);
      elem(4095, 1'b1, 0, 1'b0, 1'b0);
      elem(4096, 1'b1, 0, 1'b0, 1'b0);
      elem(-1, 1'b1, 0, 1'b0, 1'b0);
      elem(0, 1'b1, 0, 1'b0, 1'b1);
      wait_done("t3");
`ifdef OFM_POST_ROUND_EN
      qchk("t3_w0", 0, 64'h00000000FFFF0102, 4'd6);
`else
      qchk("t3_w0", 0, 64'h00000000FFFF0101, 4'd6);
`endif

      // dual valid at count 7: A closes the word, B opens the next
      do_start(5'd0);
      for (int i = 1; i <= 7; i++) elem(i, 1'b1, 0, 1'b0, 1'b0);
      elem(8, 1'b1, 9, 1'b1, 1'b0);
      elem(10, 1'b1, 11, 1'b1, 1'b0);
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      wait_done("t4");
      qchk("t4_w0", 0, 64'h0807060504030201, 4'd8);
      qchk("t4_w1", 1, 64'h00000000000B0A09, 4'd3);

      // count 7 + dual on the end_conv edge: full word then 1-byte remainder
      do_start(5'd0);
      for (int i = 1; i <= 7; i++) elem(16 + i, 1'b1, 0, 1'b0, 1'b0);
      elem(8'h18, 1'b1, 8'h19, 1'b1, 1'b1);
      wait_done("t4b");
      chk("t4b_nwords", 64'(q.size()), 64'd2);
      qchk("t4b_w0", 0, 64'h1817161514131211, 4'd8);
      qchk("t4b_w1", 1, 64'h0000000000000019, 4'd1);

      // overflow: 5 words into a 4-deep FIFO with the consumer stalled
      ob.out_ready = 1'b0;
      do_start(5'd0);
      for (int i = 0; i < 16; i++) elem(2*i, 1'b1, 2*i + 1, 1'b1, 1'b0);
      chk("t5_noovf", 64'(overflow), 64'd0);
      for (int i = 16; i < 20; i++) elem(2*i, 1'b1, 2*i + 1, 1'b1, 1'b0);
      step();
      chk("t5_ovf", 64'(overflow), 64'd1);
      chk("t5_head_stable", ob.out_data, 64'h0706050403020100);
      ob.out_ready = 1'b1;
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      wait_done("t5");
      chk("t5_nwords", 64'(q.size()), 64'd4);
      for (int j = 0; j < 4; j++) begin
         for (int b = 0; b < 8; b++) wexp[8*b +: 8] = 8'(8*j + b);
         qchk($sformatf("t5_w%0d", j), j, wexp, 4'd8);
      end
      chk("t5_sticky", 64'(overflow), 64'd1);
      do_start(5'd0);
      chk("t5_clr", 64'(overflow), 64'd0);
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      wait_done("t5b");

      // reset mid-layer with 3 words buffered, then a clean layer
      ob.out_ready = 1'b0;
      do_start(5'd0);
      for (int i = 0; i < 12; i++) elem(i, 1'b1, i, 1'b1, 1'b0);
      step();
      chk("t6_buffered", 64'(ob.out_valid), 64'd1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_valid", 64'(ob.out_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      ob.out_ready = 1'b1;
      do_start(5'd0);
      elem(8'hA1, 1'b1, 8'hA2, 1'b1, 1'b0);
      elem(0, 1'b0, 0, 1'b0, 1'b1);
      wait_done("t6");
      chk("t6_nwords", 64'(q.size()), 64'd1);
      qchk("t6_w0", 0, 64'h000000000000A2A1, 4'd2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
